// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: source select and load funct3 codes.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_MEM = 2'd0,
        WB_ALU = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/load_align.sv
// Combinational load lane select and sign/zero extension.
module load_align
    import wb_pkg::*;
#(
    parameter  int unsigned XLEN = 32,
    localparam int unsigned AL_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] DataR,
    input  logic [2:0]      funct3,
    input  logic [AL_W-1:0] addr_lo,
    output logic [XLEN-1:0] aligned
);

    logic [7:0]      byte_lane;
    logic [15:0]     half_lane;
    logic [XLEN-1:0] word_sext;
    logic [XLEN-1:0] word_zext;

    // Byte lane follows the full offset; half lane ignores offset bit 0.
    assign byte_lane = DataR[{addr_lo, 3'b000} +: 8];
    assign half_lane = DataR[{addr_lo[AL_W-1:1], 4'b0000} +: 16];

    // Word loads only pick a lane on RV64; on RV32 the word is the whole datapath.
    generate
        if (XLEN == 64) begin : g_word64
            logic [31:0] word_lane;
            assign word_lane = DataR[{addr_lo[AL_W-1], 5'b00000} +: 32];
            assign word_sext = {{(XLEN-32){word_lane[31]}}, word_lane};
            assign word_zext = {{(XLEN-32){1'b0}}, word_lane};
        end else begin : g_word32
            assign word_sext = DataR;
            assign word_zext = DataR;
        end
    endgenerate

    // funct3 decode; 011/111 fall through to the full datapath word (LD on RV64, LW on RV32).
    always_comb begin
        aligned = DataR;
        case (funct3)
            F3_LB:   aligned = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            F3_LH:   aligned = {{(XLEN-16){half_lane[15]}}, half_lane};
            F3_LW:   aligned = word_sext;
            F3_LBU:  aligned = {{(XLEN-8){1'b0}}, byte_lane};
            F3_LHU:  aligned = {{(XLEN-16){1'b0}}, half_lane};
            F3_LWU:  aligned = word_zext;
            default: aligned = DataR;
        endcase
    end

endmodule

// File: rtl/wb_stage_pipe.sv
// Registered writeback stage: source mux, stage registers and retired-instruction counter.
module wb_stage_pipe
    import wb_pkg::*;
#(
    parameter  int unsigned XLEN   = 32,
    parameter  int unsigned REG_AW = 5,
    localparam int unsigned AL_W   = $clog2(XLEN / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic              valid_in,
    input  logic [1:0]        WBSel_in,
    input  logic              RegWEn_in,
    input  logic [REG_AW-1:0] rd_in,
    input  logic [2:0]        funct3_in,
    input  logic [AL_W-1:0]   addr_lo_in,
    input  logic [XLEN-1:0]   DataR_in,
    input  logic [XLEN-1:0]   ALU_Result_in,
    input  logic [XLEN-1:0]   pcPlus4_in,
    input  logic [XLEN-1:0]   Imm_in,
    output logic              valid_out,
    output logic              RegWEn_out,
    output logic [REG_AW-1:0] rd_out,
    output logic [XLEN-1:0]   DataWB,
    output logic [63:0]       retire_cnt
);

    logic [XLEN-1:0]   load_data;
    logic [XLEN-1:0]   wb_src;

    logic              valid_q,  valid_d;
    logic              we_q,     we_d;
    logic [REG_AW-1:0] rd_q,     rd_d;
    logic [XLEN-1:0]   data_q,   data_d;
    logic [63:0]       retire_q, retire_d;
    logic              advance;

    load_align #(.XLEN(XLEN)) u_load_align (
        .DataR   (DataR_in),
        .funct3  (funct3_in),
        .addr_lo (addr_lo_in),
        .aligned (load_data)
    );

    // 4:1 writeback source select.
    always_comb begin
        wb_src = load_data;
        case (wb_sel_e'(WBSel_in))
            WB_MEM: wb_src = load_data;
            WB_ALU: wb_src = ALU_Result_in;
            WB_PC4: wb_src = pcPlus4_in;
            WB_IMM: wb_src = Imm_in;
            default: wb_src = load_data;
        endcase
    end

    assign advance = !flush_in && !stall_in;

    // Next-state: flush loads a bubble, stall holds, otherwise capture the MEM entry.
    always_comb begin
        valid_d  = valid_q;
        we_d     = we_q;
        rd_d     = rd_q;
        data_d   = data_q;
        retire_d = retire_q;
        if (flush_in) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
            rd_d    = '0;
            data_d  = '0;
        end else if (!stall_in) begin
            valid_d = valid_in;
            we_d    = RegWEn_in && valid_in && (rd_in != '0);
            rd_d    = rd_in;
            data_d  = wb_src;
        end
        if (advance && valid_in) begin
            retire_d = retire_q + 64'd1;
        end
    end

    // Stage registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            we_q     <= 1'b0;
            rd_q     <= '0;
            data_q   <= '0;
            retire_q <= '0;
        end else begin
            valid_q  <= valid_d;
            we_q     <= we_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            retire_q <= retire_d;
        end
    end

    assign valid_out  = valid_q;
    assign RegWEn_out = we_q;
    assign rd_out     = rd_q;
    assign DataWB     = data_q;
    assign retire_cnt = retire_q;

endmodule
